// File: rtl/i2c_pkg.sv
// Shared types for the I2C byte slave: FSM state encoding and the read R/W bit value.
// Pure declarations; no timing or flow control of its own.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    TX_BYTE,
    MACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_if.sv
// Two-wire I2C bus bundle with a pulled-up open-drain SDA; SCL is master-driven.
// No latency; no flow control beyond the I2C protocol itself.
interface i2c_if;

  logic scl;
  wire  sda;

  pullup (sda);

  modport slave  (input scl, inout sda);
  modport master (output scl, inout sda);

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA and flags SCL edges plus START/STOP; events lag the pins by SYNC_STAGES+1 clk.
// No backpressure: every event is a single-cycle pulse; detection stays muted until the pipeline refills after reset.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_q;
  logic                   sda_q;
  logic [SYNC_STAGES:0]   warm;
  logic                   scl;
  logic                   live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
      warm   <= '0;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
      scl_q  <= scl_sr[SYNC_STAGES-1];
      sda_q  <= sda_sr[SYNC_STAGES-1];
      warm   <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign scl = scl_sr[SYNC_STAGES-1];
  assign sda = sda_sr[SYNC_STAGES-1];

  // The all-ones reset value would fake a SDA fall under SCL high if reset drops mid-transfer
  assign live = warm[SYNC_STAGES];

  assign scl_rise  = live &  scl & ~scl_q;
  assign scl_fall  = live & ~scl &  scl_q;
  assign start_det = live &  scl &  scl_q &  sda_q & ~sda;
  assign stop_det  = live &  scl &  scl_q & ~sda_q &  sda;

endmodule

// File: rtl/i2c_byte_slave.sv
// Read-only I2C slave returning one tx_data byte per addressed read; SDA changes 1 clk after the synced SCL fall.
// tx_data is popped by a one-cycle tx_ready strobe; an empty source yields 8'hFF and an underflow pulse.
module i2c_byte_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  i2c_if.slave       i2c,
  output logic       xfer_done,
  output logic       master_ack,
  output logic       underflow
);

  i2c_state_t state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic       sda_oe, sda_oe_nx;
  logic       ack_drv, ack_drv_nx;
  logic       master_ack_nx, tx_ready_nx, xfer_done_nx, underflow_nx;
  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] addr_byte;
  logic       addr_hit;
  logic [2:0] tx_idx;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (i2c.scl),
    .sda_in    (i2c.sda),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign i2c.sda   = sda_oe ? 1'b0 : 1'bz;
  assign addr_byte = {shreg[6:0], sda_s};
  assign addr_hit  = (addr_byte[7:1] == I2C_ADDR) && (addr_byte[0] == I2C_RW_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_oe     <= 1'b0;
      ack_drv    <= 1'b0;
      master_ack <= 1'b0;
      tx_ready   <= 1'b0;
      xfer_done  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shreg      <= shreg_nx;
      sda_oe     <= sda_oe_nx;
      ack_drv    <= ack_drv_nx;
      master_ack <= master_ack_nx;
      tx_ready   <= tx_ready_nx;
      xfer_done  <= xfer_done_nx;
      underflow  <= underflow_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    shreg_nx      = shreg;
    sda_oe_nx     = sda_oe;
    ack_drv_nx    = ack_drv;
    master_ack_nx = master_ack;
    tx_ready_nx   = 1'b0;
    xfer_done_nx  = 1'b0;
    underflow_nx  = 1'b0;
    // Bit index presented after the next fall: 7 - (bit_cnt + 1)
    tx_idx        = ~(bit_cnt + 3'd1);

    if (stop_det) begin
      state_nx   = IDLE;
      sda_oe_nx  = 1'b0;
      ack_drv_nx = 1'b0;
    end else if (start_det) begin
      state_nx   = ADDR;
      bit_cnt_nx = '0;
      sda_oe_nx  = 1'b0;
      ack_drv_nx = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_nx = addr_byte;
            if (bit_cnt == 3'd7) begin
              bit_cnt_nx = '0;
              state_nx   = addr_hit ? ADDR_ACK : WAIT_STOP;
            end else begin
              bit_cnt_nx = bit_cnt + 3'd1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv) begin
              ack_drv_nx = 1'b1;
              sda_oe_nx  = 1'b1;
            end else begin
              ack_drv_nx = 1'b0;
              bit_cnt_nx = '0;
              state_nx   = TX_BYTE;
              if (tx_valid) begin
                shreg_nx    = tx_data;
                tx_ready_nx = 1'b1;
                sda_oe_nx   = ~tx_data[7];
              end else begin
                shreg_nx     = 8'hFF;
                underflow_nx = 1'b1;
                sda_oe_nx    = 1'b0;
              end
            end
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_nx = 1'b0;
              state_nx  = MACK;
            end else begin
              bit_cnt_nx = bit_cnt + 3'd1;
              sda_oe_nx  = ~shreg[tx_idx];
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            master_ack_nx = ~sda_s;
            xfer_done_nx  = 1'b1;
            state_nx      = WAIT_STOP;
          end
        end
        default: begin
          sda_oe_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_slave.sv
// Directed bench: a bit-banged I2C master reads from the slave while a byte table feeds tx_data.
`timescale 1ns/1ps
module tb_i2c_byte_slave;
  import i2c_pkg::*;

  localparam int HALF = 200;
  localparam int Q    = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid = 1'b0;
  logic       tx_ready, xfer_done, master_ack, underflow;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;

  i2c_if bus ();
  assign bus.scl = m_scl;
  assign bus.sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_byte_slave #(.I2C_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .i2c        (bus),
    .xfer_done  (xfer_done),
    .master_ack (master_ack),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_mem [0:31];
  int pops = 0, unders = 0, dones = 0;
  int checks = 0, errors = 0;

  assign tx_data = fifo_mem[pops % 32];

  always @(posedge clk) begin
    if (tx_ready)  pops   <= pops + 1;
    if (underflow) unders <= unders + 1;
    if (xfer_done) dones  <= dones + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    #Q; m_sda_low = ~b;
    #Q; m_scl = 1'b1;
    #HALF; m_scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    #Q; m_sda_low = 1'b0;
    #Q; m_scl = 1'b1;
    #Q; b = bus.sda;
    #Q; m_scl = 1'b0;
  endtask

  task automatic do_start();
    #Q; m_sda_low = 1'b0;
    #Q; m_scl = 1'b1;
    #HALF; m_sda_low = 1'b1;
    #HALF; m_scl = 1'b0;
  endtask

  task automatic do_stop();
    #Q; m_sda_low = 1'b1;
    #Q; m_scl = 1'b1;
    #HALF; m_sda_low = 1'b0;
    #HALF;
  endtask

  task automatic addr_bits(input logic [7:0] a, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(a[i]);
    bit_in(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
  endtask

  task automatic read_txn(input logic [7:0] a, input logic mack,
                          output logic ack, output logic [7:0] d);
    d = 8'hFF;
    do_start();
    addr_bits(a, ack);
    if (ack == 1'b0) begin
      read_byte(d);
      bit_out(mack ? 1'b0 : 1'b1);
    end
    do_stop();
  endtask

  initial begin
    logic       ack, b;
    logic [7:0] d;
    logic [2:0] part;
    int p0, u0, x0;

    fifo_mem[0] = 8'hA5;
    fifo_mem[1] = 8'h69;
    fifo_mem[2] = 8'h3C;
    fifo_mem[3] = 8'hC3;
    fifo_mem[4] = 8'h12;
    fifo_mem[5] = 8'h5A;
    for (int i = 0; i < 16; i++) fifo_mem[6+i] = 8'(i);
    for (int i = 22; i < 32; i++) fifo_mem[i] = 8'hEE;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_sda", 32'(bus.sda), 32'd1);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_xfer_done", 32'(xfer_done), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_master_ack", 32'(master_ack), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain read with data available, master ACK
    tx_valid = 1'b1;
    p0 = pops; u0 = unders; x0 = dones;
    read_txn(8'h85, 1'b1, ack, d);
    check("rd_addr_ack", 32'(ack), 32'd0);
    check("rd_data", 32'(d), 32'hA5);
    check("rd_pops", 32'(pops - p0), 32'd1);
    check("rd_done", 32'(dones - x0), 32'd1);
    check("rd_master_ack", 32'(master_ack), 32'd1);
    check("rd_no_underflow", 32'(unders - u0), 32'd0);

    // Empty source: 0xFF, underflow pulse, no pop; master NACK
    tx_valid = 1'b0;
    p0 = pops; u0 = unders; x0 = dones;
    read_txn(8'h85, 1'b0, ack, d);
    check("uf_addr_ack", 32'(ack), 32'd0);
    check("uf_data", 32'(d), 32'hFF);
    check("uf_underflow", 32'(unders - u0), 32'd1);
    check("uf_pops", 32'(pops - p0), 32'd0);
    check("uf_master_nack", 32'(master_ack), 32'd0);
    check("uf_done", 32'(dones - x0), 32'd1);

    // Write direction and foreign address are ignored
    tx_valid = 1'b1;
    p0 = pops; x0 = dones;
    read_txn(8'h84, 1'b1, ack, d);
    check("wr_nack", 32'(ack), 32'd1);
    read_txn(8'h87, 1'b1, ack, d);
    check("addr43_nack", 32'(ack), 32'd1);
    check("nack_pops", 32'(pops - p0), 32'd0);
    check("nack_done", 32'(dones - x0), 32'd0);
    read_txn(8'h85, 1'b1, ack, d);
    check("after_nack_ack", 32'(ack), 32'd0);
    check("after_nack_data", 32'(d), 32'h69);

    // Repeated START three bits into a byte
    p0 = pops;
    do_start();
    addr_bits(8'h85, ack);
    check("rs_addr_ack", 32'(ack), 32'd0);
    for (int i = 2; i >= 0; i--) begin
      bit_in(b);
      part[i] = b;
    end
    check("rs_partial_bits", 32'(part), 32'h1);
    do_start();
    check("rs_state_addr", 32'(dut.state), 32'(ADDR));
    addr_bits(8'h85, ack);
    check("rs_second_ack", 32'(ack), 32'd0);
    read_byte(d);
    bit_out(1'b0);
    do_stop();
    check("rs_data", 32'(d), 32'hC3);
    check("rs_pops", 32'(pops - p0), 32'd2);

    // Reset while the slave holds SDA low in TX_BYTE
    do_start();
    addr_bits(8'h85, ack);
    #Q;
    check("mid_sda_low", 32'(bus.sda), 32'd0);
    check("mid_state", 32'(dut.state), 32'(TX_BYTE));
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_sda", 32'(bus.sda), 32'd1);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_outs", 32'({tx_ready, xfer_done, underflow, master_ack}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    read_byte(d);
    check("post_rst_silent", 32'(d), 32'hFF);
    do_stop();
    read_txn(8'h85, 1'b1, ack, d);
    check("post_rst_ack", 32'(ack), 32'd0);
    check("post_rst_data", 32'(d), 32'h5A);

    // Sixteen back-to-back reads
    p0 = pops; x0 = dones;
    for (int i = 0; i < 16; i++) begin
      read_txn(8'h85, 1'b1, ack, d);
      check($sformatf("b2b_%0d", i), 32'({ack, d}), 32'(i));
    end
    check("b2b_pops", 32'(pops - p0), 32'd16);
    check("b2b_done", 32'(dones - x0), 32'd16);
    check("b2b_idle", 32'(dut.state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
